dmem_arbiter: RTL and testbench

- Sequences and shares the single-port data memory between two requesters.
- Port A is the pipeline MEM stage; port B is the debug/loader port.
- Drives the memory address, write data, func3 and read/write enables. Holds each access for a fixed multi-cycle latency, then returns a one-cycle done pulse with registered read data.
- Gives A fixed priority, with a starvation guard that guarantees B forward progress. Provides a combinational stall for the pipeline.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports (A = pipeline MEM stage, B = debug/loader),
// the single-port data memory connection and the arbiter status outputs.
//
//   slave  : arbiter view - requests and mem_out in; memory drive,
//            done pulses, rdata, a_stall and busy out.
//   master : environment view (requesters + memory) - the mirror image.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if;
    // requester A
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [2:0]  a_func3;
    // requester B
    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_func3;
    // memory side
    logic [31:0] mem_out;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [2:0]  mem_func3;
    logic        mem_read_ena;
    logic        mem_write_ena;
    // completion / status
    logic        a_done;
    logic        b_done;
    logic [31:0] rdata;
    logic        a_stall;
    logic        busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_func3,
        input  b_req, b_we, b_addr, b_wdata, b_func3,
        input  mem_out,
        output mem_addr, mem_data, mem_func3, mem_read_ena, mem_write_ena,
        output a_done, b_done, rdata, a_stall, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_func3,
        output b_req, b_we, b_addr, b_wdata, b_func3,
        output mem_out,
        input  mem_addr, mem_data, mem_func3, mem_read_ena, mem_write_ena,
        input  a_done, b_done, rdata, a_stall, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between requester A (pipeline MEM stage,
// fixed priority) and requester B (debug/loader). Each access occupies the
// memory for MEM_LATENCY cycles, followed by a one-cycle done pulse to the
// owner with the captured read data on rdata. A starvation counter forces B
// to win after STARVE_LIMIT consecutive A grants taken while B was waiting.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset (aborts any access in flight)
//   bus    - dmem_arbiter_if.slave: A/B requests, memory interface,
//            a_done/b_done, rdata, a_stall (comb), busy
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MEM_LATENCY  = 1,   // 1..8
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] LAST_CNT  = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] LIMIT_CNT = 4'(STARVE_LIMIT);

    state_t      state_reg, state_next;
    logic        owner_reg;           // 0 = A, 1 = B
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  func3_reg;
    logic [3:0]  lat_cnt_reg;
    logic [3:0]  starve_cnt_reg;
    logic [31:0] rdata_reg;

    logic grant_any;
    logic grant_b;
    logic last_cycle;

    logic mem_read_ena_c;
    logic mem_write_ena_c;
    logic a_done_c;
    logic b_done_c;
    logic busy_c;

    // Arbitration: B wins when alone, or when A has starved it long enough.
    always_comb begin
        grant_any = bus.a_req | bus.b_req;
        grant_b   = bus.b_req & (~bus.a_req | (starve_cnt_reg == LIMIT_CNT));
    end

    assign last_cycle = (lat_cnt_reg == LAST_CNT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any)  state_next = BUSY;
            BUSY:    if (last_cycle) state_next = DONE;
            DONE:    state_next = IDLE;   // requests ignored during DONE
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_read_ena_c  = 1'b0;
        mem_write_ena_c = 1'b0;
        a_done_c        = 1'b0;
        b_done_c        = 1'b0;
        busy_c          = 1'b0;
        case (state_reg)
            BUSY: begin
                busy_c          = 1'b1;
                mem_read_ena_c  = ~we_reg;
                // Writes strobe only once, in the first BUSY cycle.
                mem_write_ena_c = we_reg & (lat_cnt_reg == 4'd0);
            end
            DONE: begin
                busy_c   = 1'b1;
                a_done_c = ~owner_reg;
                b_done_c = owner_reg;
            end
            default: ;
        endcase
    end

    // ---------------- Datapath / counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_reg      <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            func3_reg      <= '0;
            lat_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            rdata_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        owner_reg   <= grant_b;
                        we_reg      <= grant_b ? bus.b_we    : bus.a_we;
                        addr_reg    <= grant_b ? bus.b_addr  : bus.a_addr;
                        wdata_reg   <= grant_b ? bus.b_wdata : bus.a_wdata;
                        func3_reg   <= grant_b ? bus.b_func3 : bus.a_func3;
                        lat_cnt_reg <= '0;
                        // Count only A grants that made a waiting B wait longer.
                        if (grant_b || !bus.b_req) begin
                            starve_cnt_reg <= '0;
                        end else if (starve_cnt_reg < LIMIT_CNT) begin
                            starve_cnt_reg <= starve_cnt_reg + 4'd1;
                        end
                    end
                end
                BUSY: begin
                    lat_cnt_reg <= lat_cnt_reg + 4'd1;
                    if (last_cycle && !we_reg) begin
                        rdata_reg <= bus.mem_out;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory address/data/func3 hold their last value outside BUSY.
    assign bus.mem_addr      = addr_reg;
    assign bus.mem_data      = wdata_reg;
    assign bus.mem_func3     = func3_reg;
    assign bus.mem_read_ena  = mem_read_ena_c;
    assign bus.mem_write_ena = mem_write_ena_c;
    assign bus.a_done        = a_done_c;
    assign bus.b_done        = b_done_c;
    assign bus.rdata         = rdata_reg;
    assign bus.busy          = busy_c;
    assign bus.a_stall       = bus.a_req & ~a_done_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Scoreboard bench: expected completions are queued per port when a request
// is driven and popped by a monitor when the matching done pulse appears.
// A second instance with MEM_LATENCY = 8 covers the long-latency corner.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int LAT   = 3;
    localparam int LIMIT = 2;
    localparam int LAT8  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus8();

    dmem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dmem_arbiter #(.MEM_LATENCY(LAT8), .STARVE_LIMIT(4)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem_array [0:63];
    logic        mem_init;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'hC0DE0000 | 32'(i * 17);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_array[i] <= init_word(i);
        end else if (bus.mem_write_ena) begin
            mem_array[bus.mem_addr[7:2]] <= bus.mem_data;
        end
    end

    assign bus.mem_out  = mem_array[bus.mem_addr[7:2]];
    assign bus8.mem_out = bus8.mem_addr ^ 32'hFFFF_0000;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [31:0] ref_mem [0:63];
    logic [31:0] model_rdata;
    bit          order_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        exp_t e;
        e.we = we;
        if (we) begin
            ref_mem[addr[7:2]] = wdata;
            e.data = '0;
        end else begin
            e.data = ref_mem[addr[7:2]];
        end
        if (port) exp_b.push_back(e);
        else      exp_a.push_back(e);
    endtask

    task automatic score(input bit port);
        exp_t e;
        int   n;
        order_q.push_back(port);
        n = port ? exp_b.size() : exp_a.size();
        check_val(port ? "b_done_expected" : "a_done_expected", 32'(n > 0), 32'd1);
        if (n > 0) begin
            if (port) e = exp_b.pop_front();
            else      e = exp_a.pop_front();
            // Writes leave rdata holding the last read value.
            if (!e.we) model_rdata = e.data;
            check_val(port ? "b_rdata" : "a_rdata", bus.rdata, model_rdata);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.a_done) score(1'b0);
            if (bus.b_done) score(1'b1);
        end
    end

    // ---------------- single access with timing checks ----------------
    task automatic access(input bit port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
        int rd_n = 0;
        int wr_n = 0;
        int busy_n = 0;
        bit seen = 1'b0;
        @(posedge clk); #1;
        push_exp(port, we, addr, wdata);
        if (!port) begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr;
            bus.a_wdata = wdata; bus.a_func3 = f3;
        end else begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr;
            bus.b_wdata = wdata; bus.b_func3 = f3;
        end
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) check_val("idle_busy", 32'(bus.busy), 32'd0);
            if (k == 1) begin
                check_val("mem_addr", bus.mem_addr, addr);
                check_val("first_wr_ena", 32'(bus.mem_write_ena), 32'(we));
                if (we) begin
                    check_val("mem_data", bus.mem_data, wdata);
                    check_val("mem_func3", 32'(bus.mem_func3), 32'(f3));
                end
            end
            if (!port && k <= LAT) check_val("a_stall", 32'(bus.a_stall), 32'd1);
            rd_n   += int'(bus.mem_read_ena);
            wr_n   += int'(bus.mem_write_ena);
            busy_n += int'(bus.busy);
            if (port ? bus.b_done : bus.a_done) begin
                seen = 1'b1;
                check_val("done_cycle", 32'(k), 32'(LAT + 1));
                check_val("rd_ena_cycles", 32'(rd_n), we ? 32'd0 : 32'(LAT));
                check_val("wr_ena_cycles", 32'(wr_n), we ? 32'd1 : 32'd0);
                check_val("busy_cycles", 32'(busy_n), 32'(LAT + 1));
                if (!port) check_val("a_stall_done", 32'(bus.a_stall), 32'd0);
                if (!port) bus.a_req = 1'b0;
                else       bus.b_req = 1'b0;
            end
        end
        check_val("done_seen", 32'(seen), 32'd1);
        $display("access port=%0d we=%0d addr=%h wdata=%h", port, we, addr, wdata);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        bit exp_order [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int ka, kb, na, nb, rd8, kd;

        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0; bus.a_func3 = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_func3 = 0;
        bus8.a_req = 0; bus8.a_we = 0; bus8.a_addr = 0; bus8.a_wdata = 0; bus8.a_func3 = 0;
        bus8.b_req = 0; bus8.b_we = 0; bus8.b_addr = 0; bus8.b_wdata = 0; bus8.b_func3 = 0;
        mem_init = 1'b1;
        model_rdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mem_init = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_busy",   32'(bus.busy), 32'd0);
        check_val("rst_a_done", 32'(bus.a_done), 32'd0);
        check_val("rst_b_done", 32'(bus.b_done), 32'd0);
        check_val("rst_rdata",  bus.rdata, 32'd0);
        check_val("rst_addr",   bus.mem_addr, 32'd0);
        check_val("rst_rd_ena", 32'(bus.mem_read_ena), 32'd0);
        check_val("rst_wr_ena", 32'(bus.mem_write_ena), 32'd0);
        check_val("rst_stall",  32'(bus.a_stall), 32'd0);
        $display("reset state checked");

        // Basic reads/writes on both ports
        access(1'b0, 1'b0, 32'h10, 32'h0, 3'b010);
        access(1'b0, 1'b1, 32'h20, 32'h12345678, 3'b010);
        access(1'b0, 1'b0, 32'h20, 32'h0, 3'b010);
        access(1'b1, 1'b0, 32'h30, 32'h0, 3'b100);
        access(1'b1, 1'b1, 32'h34, 32'hCAFEF00D, 3'b001);
        access(1'b1, 1'b0, 32'h34, 32'h0, 3'b010);

        // Simultaneous requests: A first, B right after
        @(posedge clk); #1;
        push_exp(1'b0, 1'b0, 32'h40, 32'h0);
        push_exp(1'b1, 1'b0, 32'h44, 32'h0);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h40;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h44;
        ka = -1; kb = -1;
        for (int k = 0; k < 40 && (ka < 0 || kb < 0); k++) begin
            @(negedge clk);
            if (bus.a_done) begin ka = k; bus.a_req = 0; end
            if (bus.b_done) begin kb = k; bus.b_req = 0; end
        end
        check_val("simul_a_done_cycle", 32'(ka), 32'(LAT + 1));
        check_val("simul_b_done_cycle", 32'(kb), 32'(2 * LAT + 3));
        $display("simultaneous a_done@%0d b_done@%0d", ka, kb);

        // Starvation: A continuous, B held for two grants
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) push_exp(1'b0, 1'b0, 32'h48, 32'h0);
        for (int i = 0; i < 2; i++) push_exp(1'b1, 1'b0, 32'h4C, 32'h0);
        order_q.delete();
        bus.a_req = 1; bus.a_addr = 32'h48;
        bus.b_req = 1; bus.b_addr = 32'h4C;
        na = 0; nb = 0;
        for (int k = 0; k < 100 && (bus.a_req || bus.b_req); k++) begin
            @(negedge clk);
            if (bus.a_done) begin na++; if (na == 5) bus.a_req = 0; end
            if (bus.b_done) begin nb++; if (nb == 2) bus.b_req = 0; end
        end
        @(posedge clk);
        check_val("starve_grants", 32'(order_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < order_q.size(); i++) begin
            check_val($sformatf("starve_order[%0d]", i), 32'(order_q[i]), 32'(exp_order[i]));
        end
        $display("starvation sequence: %0d grants", order_q.size());

        // Reset in the second BUSY cycle of a B write
        #1;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h50;
        bus.b_wdata = 32'h0BADC0DE; bus.b_func3 = 3'b010;
        ref_mem[20] = 32'h0BADC0DE;
        @(posedge clk);   // request sampled, BUSY cycle 1 begins
        @(posedge clk);   // BUSY cycle 2 begins
        #1 reset = 1'b1;
        #1;
        check_val("midrst_busy",   32'(bus.busy), 32'd0);
        check_val("midrst_wr_ena", 32'(bus.mem_write_ena), 32'd0);
        check_val("midrst_rd_ena", 32'(bus.mem_read_ena), 32'd0);
        check_val("midrst_b_done", 32'(bus.b_done), 32'd0);
        check_val("midrst_addr",   bus.mem_addr, 32'd0);
        check_val("midrst_data",   bus.mem_data, 32'd0);
        check_val("midrst_func3",  32'(bus.mem_func3), 32'd0);
        check_val("midrst_rdata",  bus.rdata, 32'd0);
        bus.b_req = 0; bus.b_we = 0;
        model_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        $display("mid-operation reset applied");
        access(1'b0, 1'b0, 32'h10, 32'h0, 3'b010);

        // Long latency instance
        @(posedge clk); #1;
        bus8.a_req = 1; bus8.a_we = 0; bus8.a_addr = 32'h40;
        rd8 = 0; kd = -1;
        for (int k = 0; k < 40 && kd < 0; k++) begin
            @(negedge clk);
            rd8 += int'(bus8.mem_read_ena);
            if (bus8.a_done) begin
                kd = k;
                check_val("lat8_rdata", bus8.rdata, 32'h40 ^ 32'hFFFF_0000);
                bus8.a_req = 0;
            end
        end
        check_val("lat8_done_cycle", 32'(kd), 32'(LAT8 + 1));
        check_val("lat8_rd_cycles", 32'(rd8), 32'(LAT8));
        $display("latency-8 read done@%0d rd_ena=%0d", kd, rd8);

        repeat (3) @(posedge clk);
        check_val("leftover_a", 32'(exp_a.size()), 32'd0);
        check_val("leftover_b", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
